// File: rtl/bus_timer_fifo_responder.sv
// bus_timer_fifo_responder
//   Memory-mapped peripheral on the CPU data bus. It holds a prescaled 32-bit
//   timer with compare match and interrupt, plus an output FIFO that drains to
//   an external consumer over a valid/ready handshake.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   addr, cs, wr_rd  bus address (only addr[4:2] decoded), select, 1=write
//   data_bus_write   bus write data
//   data_bus_read    combinational read data, 0 when cs=0
//   irq              match_flag & CTRL.ien
//   out_data         FIFO head
//   out_valid        FIFO non-empty
//   out_ready        consumer accepts head this cycle
//
// Register map (addr[4:2])
//   0 CTRL     {ien, autoreload, en}
//   1 STATUS   [15:8] fifo count, [3] overflow W1C, [2] full, [1] empty,
//              [0] match_flag W1C
//   2 PRESCALE 3 COMPARE 4 COUNT 5 FIFO (write pushes, read peeks head)
module bus_timer_fifo_responder #(
  parameter int FIFO_DEPTH = 8,
  parameter int PRESCALE_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        cs,
  input  logic        wr_rd,
  input  logic [31:0] data_bus_write,
  output logic [31:0] data_bus_read,
  output logic        irq,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [2:0] OFF_CTRL     = 3'd0;
  localparam logic [2:0] OFF_STATUS   = 3'd1;
  localparam logic [2:0] OFF_PRESCALE = 3'd2;
  localparam logic [2:0] OFF_COMPARE  = 3'd3;
  localparam logic [2:0] OFF_COUNT    = 3'd4;
  localparam logic [2:0] OFF_FIFO     = 3'd5;

  logic [2:0]            ctrl;
  logic                  match_flag;
  logic                  overflow;
  logic [PRESCALE_W-1:0] prescale;
  logic [PRESCALE_W-1:0] pre_cnt;
  logic [31:0]           compare;
  logic [31:0]           count;

  logic [31:0]           mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      fifo_cnt;

  logic [2:0] off;
  logic       we, tick, hit;
  logic       fifo_empty, fifo_full, push, pop, do_push;
  logic [7:0] cnt8;

  // Upper/lower address bits are decoded by the CPU, not here.
  logic unused_addr;
  assign unused_addr = ^{addr[31:5], addr[1:0]};

  assign off  = addr[4:2];
  assign we   = cs & wr_rd;
  assign tick = ctrl[0] && (pre_cnt == prescale);
  assign hit  = tick && (count == compare);

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == CNT_W'(FIFO_DEPTH));
  assign push       = we && (off == OFF_FIFO);
  assign pop        = out_valid & out_ready;
  // A push into a full FIFO only lands if the same edge frees a slot.
  assign do_push    = push && (!fifo_full || pop);

  assign out_valid = !fifo_empty;
  assign out_data  = mem[rd_ptr];
  assign irq       = match_flag & ctrl[2];
  assign cnt8      = 8'(fifo_cnt);

  always_comb begin
    data_bus_read = '0;
    if (cs && !wr_rd) begin
      case (off)
        OFF_CTRL:     data_bus_read = {29'd0, ctrl};
        OFF_STATUS:   data_bus_read = {16'd0, cnt8, 4'd0, overflow, fifo_full,
                                       fifo_empty, match_flag};
        OFF_PRESCALE: data_bus_read = 32'(prescale);
        OFF_COMPARE:  data_bus_read = compare;
        OFF_COUNT:    data_bus_read = count;
        OFF_FIFO:     data_bus_read = out_valid ? out_data : 32'd0;
        default:      data_bus_read = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl       <= '0;
      match_flag <= 1'b0;
      overflow   <= 1'b0;
      prescale   <= '0;
      pre_cnt    <= '0;
      compare    <= '0;
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
    end else begin
      if (we && off == OFF_CTRL)     ctrl     <= data_bus_write[2:0];
      if (we && off == OFF_PRESCALE) prescale <= data_bus_write[PRESCALE_W-1:0];
      if (we && off == OFF_COMPARE)  compare  <= data_bus_write;

      // Bus write to COUNT beats a coincident tick.
      if (we && off == OFF_COUNT)
        count <= data_bus_write;
      else if (tick)
        count <= (hit && ctrl[1]) ? 32'd0 : count + 32'd1;

      // Reprogramming COUNT or PRESCALE restarts the prescale period.
      if ((we && (off == OFF_COUNT || off == OFF_PRESCALE)) || tick)
        pre_cnt <= '0;
      else if (ctrl[0])
        pre_cnt <= pre_cnt + 1'b1;

      // Set beats W1C clear on the same edge.
      match_flag <= hit | (match_flag &
                    ~(we && off == OFF_STATUS && data_bus_write[0]));
      overflow   <= (push && fifo_full && !pop) | (overflow &
                    ~(we && off == OFF_STATUS && data_bus_write[3]));

      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked by fifo_cnt.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data_bus_write;
  end

endmodule

// File: doc/bus_timer_fifo_responder.md
Name: bus_timer_fifo_responder

Overview:
Memory-mapped peripheral that answers the CPU's data-bus accesses (addr, cs, wr_rd, data_bus_write → data_bus_read).
- Responder side of the CPU load/store bus.
- Contains a prescaled 32-bit timer with compare/interrupt.
- Contains an output FIFO that drains to an external consumer over a valid/ready handshake.
- Sits on the MEM stage bus. cs comes from the CPU address decoder, so the block only decodes the low offset bits.

Parameters:
FIFO_DEPTH, 8, number of 32-bit FIFO entries; power of two, 2..64
PRESCALE_W, 16, width of the prescaler reload register

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
addr  in  32  bus byte address; only addr[4:2] is used, other bits ignored
cs  in  1  peripheral selected this cycle
wr_rd  in  1  1 = write, 0 = read; meaningful only with cs=1
data_bus_write  in  32  write data
data_bus_read  out  32  read data, combinational from addr[4:2] and register state
irq  out  1  interrupt, = match_flag & CTRL.ien
out_data  out  32  FIFO head
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accepts head when out_valid=1

Behaviour:
Clock and reset:
- One clock: clk. Reset is synchronous and active-high: rst.

Bus access rules:
- A write occurs iff cs=1 and wr_rd=1. It takes effect at that clk edge.
- A read is cs=1, wr_rd=0. data_bus_read is valid in the same cycle, with zero wait states, because the CPU has no stall input.
- Reads have no side effects.
- When cs=0, data_bus_read = 0.
- Unmapped offsets read 0; writes to them are ignored.

Register map (offset = addr[4:2]):
- 0 CTRL RW: bit0 en, bit1 autoreload, bit2 ien; other bits read 0.
- 1 STATUS: bit0 match_flag (W1C), bit1 fifo_empty (R), bit2 fifo_full (R), bit3 overflow (W1C), bits[15:8] fifo count (R).
- 2 PRESCALE RW: low PRESCALE_W bits.
- 3 COMPARE RW.
- 4 COUNT RW.
- 5 FIFO: write pushes data_bus_write; read returns the head (0 if empty) without popping.

Reset:
- All registers, pre_cnt, FIFO pointers and count are cleared.
- out_valid=0, irq=0, data_bus_read=0 (cs=0).
- FIFO storage contents are don't-care.

Timer:
- While CTRL.en=1, pre_cnt increments each cycle.
- tick occurs when pre_cnt==PRESCALE. On tick, pre_cnt←0.
- PRESCALE=0 gives a tick every cycle.
- On tick: if COUNT==COMPARE, set match_flag, and COUNT←0 if autoreload, else COUNT←COUNT+1. Otherwise COUNT←COUNT+1.
- COUNT wraps modulo 2^32.
- When en=0, pre_cnt and COUNT hold.
- A bus write to COUNT or PRESCALE in the same cycle as a tick wins, and pre_cnt←0.
- A W1C of match_flag coinciding with a new match leaves match_flag=1 (set wins).

FIFO:
- push = write to offset 5; pop = out_valid & out_ready.
- Pop delivers out_data at that edge; the head advances.
- Push when full without a simultaneous pop: data dropped, overflow←1, state unchanged.
- Push and pop in the same cycle when full: both occur; count stays FIFO_DEPTH.
- Push and pop in the same cycle when non-empty and not full: count unchanged.
- Push when empty: out_valid rises the next cycle; there is no fall-through.
- Pointers wrap modulo FIFO_DEPTH. Count is FIFO_DEPTH+1 states wide.
- overflow write-1-clear coinciding with a new overflow leaves overflow=1.
- out_data is stable while out_valid=1 and out_ready=0.

Reset mid-operation:
- Any pending FIFO data and timer state are discarded. The block returns to reset values at the next edge with rst=1, regardless of cs or out_ready.

Test Plan:
1. Reset, then read offsets 0–5 with cs=1, wr_rd=0 → 0, 0x0000_0002, 0, 0, 0, 0; irq=0, out_valid=0; with cs=0, data_bus_read=0.
2. PRESCALE=3, COMPARE=5, CTRL=0b111 → COUNT increments every 4 cycles; at the 6th tick (COUNT 5→0) match_flag=1 and irq=1; write STATUS=0x1 → irq=0 next cycle.
3. CTRL=0b001, COMPARE=2 → after the match, COUNT continues 3, 4…; COUNT=0xFFFF_FFFF wraps to 0; a bus write COUNT=0x10 on a tick cycle leaves COUNT=0x10.
4. out_ready=0, push 9 words 0xA0..0xA8 (depth 8) → fifo_full=1, count=8, overflow=1, 0xA8 dropped; out_data=0xA0 held stable; write STATUS=0x8 clears overflow.
5. FIFO full, push 0xB0 with out_ready=1 in the same cycle → 0xA0 popped, 0xB0 accepted, count=8, overflow stays 0; draining yields 0xA1..0xA7, 0xB0, then out_valid=0.
6. FIFO holding 3 entries and timer running, assert rst for 1 cycle → next cycle out_valid=0, COUNT=0, CTRL=0, STATUS reads 0x0000_0002.
